// File: rtl/analog_axis_pkg.sv
// Shared types and arithmetic helpers for the analog axis emulator.
package analog_axis_pkg;

  typedef enum logic [1:0] {
    MODE_ANALOG = 2'd0,
    MODE_MOUSE  = 2'd1,
    MODE_RAMP   = 2'd2,
    MODE_AUTO   = 2'd3
  } mode_e;

  // Limit v to the signed range of a w-bit two's complement value.
  function automatic int saturate(input int v, input int w);
    int hi;
    int lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic int clamp(input int v, input int lim);
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

endpackage

// File: rtl/axis_accum.sv
// One saturating axis accumulator: clear, add a mouse delta, or ramp by a fixed step.
module axis_accum
  import analog_axis_pkg::*;
#(
  parameter int W         = 8,
  parameter int RAMP_STEP = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clr_i,
  input  logic                add_i,
  input  logic signed [8:0]   delta_i,
  input  logic                ramp_i,
  input  logic                inc_i,
  input  logic                dec_i,
  output logic signed [W-1:0] acc_next_o
);

  logic signed [W-1:0] acc_q, acc_d;
  logic signed [W+1:0] sum;
  int                  cur;

  always_comb begin
    acc_d = acc_q;
    sum   = '0;
    cur   = int'(acc_q);
    if (clr_i) begin
      acc_d = '0;
    end else if (add_i) begin
      sum   = (W + 2)'(acc_q) + (W + 2)'(delta_i);
      acc_d = W'(saturate(int'(sum), W));
    end else if (ramp_i) begin
      if (inc_i && !dec_i) begin
        acc_d = W'(saturate(cur + RAMP_STEP, W));
      end else if (dec_i && !inc_i) begin
        acc_d = W'(saturate(cur - RAMP_STEP, W));
      end else if (cur > RAMP_STEP) begin
        acc_d = W'(cur - RAMP_STEP);
      end else if (cur < -RAMP_STEP) begin
        acc_d = W'(cur + RAMP_STEP);
      end else begin
        // Within one step of centre: land exactly on zero.
        acc_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_next_o = acc_d;

endmodule

// File: rtl/analog_axis_emu.sv
// Multi-channel joystick axis emulator: analog passthrough, PS/2 mouse accumulation,
// digital ramping, and an auto mode that hands each channel to whichever source moved last.
module analog_axis_emu
  import analog_axis_pkg::*;
#(
  parameter int W         = 8,
  parameter int NCH       = 2,
  parameter int MAXSTEP   = 10,
  parameter int RAMP_DIV  = 65536,
  parameter int RAMP_STEP = 4,
  parameter int DEADZONE  = 16
) (
  input  logic                                    clk_sys,
  input  logic                                    reset_n,
  input  logic [24:0]                             ps2_mouse,
  input  logic [(NCH > 1 ? $clog2(NCH) : 1)-1:0]  mouse_ch,
  input  logic [2*NCH-1:0]                        mode,
  input  logic [W*NCH-1:0]                        ana_x,
  input  logic [W*NCH-1:0]                        ana_y,
  input  logic [5*NCH-1:0]                        dig,
  input  logic [NCH-1:0]                          ana_fire,
  input  logic                                    recenter,
  output logic [W*NCH-1:0]                        axis_x,
  output logic [W*NCH-1:0]                        axis_y,
  output logic [NCH-1:0]                          fire,
  output logic [NCH-1:0]                          mouse_active
);

  localparam int CntW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  logic              strobe_q, armed_q;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              tick, pkt;
  logic signed [8:0] dx_raw, dy_raw, dx, dy_neg;
  logic              unused_ps2;

  assign unused_ps2 = ^{ps2_mouse[7:6], ps2_mouse[3:2]};

  assign tick  = (cnt_q == CntW'(RAMP_DIV - 1));
  assign cnt_d = tick ? '0 : cnt_q + CntW'(1);

  // armed_q masks the cycle after reset so the strobe copy can settle first.
  assign pkt = armed_q & (ps2_mouse[24] ^ strobe_q) & ~recenter & (32'(mouse_ch) < NCH);

  assign dx_raw = {ps2_mouse[4], ps2_mouse[15:8]};
  assign dy_raw = {ps2_mouse[5], ps2_mouse[23:16]};
  assign dx     = 9'(clamp(int'(dx_raw), MAXSTEP));
  assign dy_neg = 9'(-clamp(int'(dy_raw), MAXSTEP));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      strobe_q <= 1'b0;
      armed_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      strobe_q <= ps2_mouse[24];
      armed_q  <= 1'b1;
      cnt_q    <= cnt_d;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : gen_ch
    mode_e               m;
    logic signed [W-1:0] ax, ay, nxt_x, nxt_y;
    logic signed [W-1:0] axis_x_d, axis_x_q, axis_y_d, axis_y_q;
    logic [4:0]          d;
    logic                act_q, act_d, stick, ch_pkt, use_mouse, clr, add, ramp;
    logic                fire_d, fire_q;

    assign m      = mode_e'(mode[2*c +: 2]);
    assign ax     = ana_x[W*c +: W];
    assign ay     = ana_y[W*c +: W];
    assign d      = dig[5*c +: 5];
    assign ch_pkt = pkt & (32'(mouse_ch) == c);
    assign stick  = (int'(ax) > DEADZONE) || (int'(ax) < -DEADZONE) ||
                    (int'(ay) > DEADZONE) || (int'(ay) < -DEADZONE) || (|d);

    // Ownership only moves while in auto mode; recenter always drops it.
    always_comb begin
      act_d = act_q;
      if (recenter) begin
        act_d = 1'b0;
      end else if (m == MODE_AUTO) begin
        if (stick) begin
          act_d = 1'b0;
        end else if (ch_pkt) begin
          act_d = 1'b1;
        end
      end
    end

    assign use_mouse = (m == MODE_MOUSE) || ((m == MODE_AUTO) && act_d);
    assign clr       = recenter | (act_q & ~act_d);
    assign add       = ch_pkt & use_mouse;
    assign ramp      = tick & (m == MODE_RAMP);

    axis_accum #(
      .W        (W),
      .RAMP_STEP(RAMP_STEP)
    ) u_acc_x (
      .clk_i     (clk_sys),
      .rst_ni    (reset_n),
      .clr_i     (clr),
      .add_i     (add),
      .delta_i   (dx),
      .ramp_i    (ramp),
      .inc_i     (d[0]),
      .dec_i     (d[1]),
      .acc_next_o(nxt_x)
    );

    axis_accum #(
      .W        (W),
      .RAMP_STEP(RAMP_STEP)
    ) u_acc_y (
      .clk_i     (clk_sys),
      .rst_ni    (reset_n),
      .clr_i     (clr),
      .add_i     (add),
      .delta_i   (dy_neg),
      .ramp_i    (ramp),
      .inc_i     (d[3]),
      .dec_i     (d[2]),
      .acc_next_o(nxt_y)
    );

    always_comb begin
      axis_x_d = ax;
      axis_y_d = ay;
      fire_d   = ana_fire[c];
      unique case (m)
        MODE_MOUSE: begin
          axis_x_d = nxt_x;
          axis_y_d = nxt_y;
          fire_d   = |ps2_mouse[1:0];
        end
        MODE_RAMP: begin
          axis_x_d = nxt_x;
          axis_y_d = nxt_y;
          fire_d   = d[4];
        end
        MODE_AUTO: begin
          if (act_d) begin
            axis_x_d = nxt_x;
            axis_y_d = nxt_y;
            fire_d   = |ps2_mouse[1:0];
          end else begin
            fire_d = ana_fire[c] | d[4];
          end
        end
        default: ;
      endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        axis_x_q <= '0;
        axis_y_q <= '0;
        fire_q   <= 1'b0;
        act_q    <= 1'b0;
      end else begin
        axis_x_q <= axis_x_d;
        axis_y_q <= axis_y_d;
        fire_q   <= fire_d;
        act_q    <= act_d;
      end
    end

    assign axis_x[W*c +: W] = axis_x_q;
    assign axis_y[W*c +: W] = axis_y_q;
    assign fire[c]          = fire_q;
    assign mouse_active[c]  = act_q;
  end

endmodule

// File: tb/tb_analog_axis_emu.sv
// Directed and randomized bench for analog_axis_emu with a cycle-level behavioural model.
module tb_analog_axis_emu;

  localparam int W         = 8;
  localparam int NCH       = 2;
  localparam int MAXSTEP   = 10;
  localparam int RAMP_DIV  = 8;
  localparam int RAMP_STEP = 4;
  localparam int DEADZONE  = 16;
  localparam int LO        = -(1 << (W - 1));
  localparam int HI        = (1 << (W - 1)) - 1;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic [24:0]      ps2_mouse = '0;
  logic [0:0]       mouse_ch  = '0;
  logic [2*NCH-1:0] mode      = '0;
  logic [W*NCH-1:0] ana_x     = '0;
  logic [W*NCH-1:0] ana_y     = '0;
  logic [5*NCH-1:0] dig       = '0;
  logic [NCH-1:0]   ana_fire  = '0;
  logic             recenter  = 1'b0;
  logic [W*NCH-1:0] axis_x, axis_y;
  logic [NCH-1:0]   fire, mouse_active;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  analog_axis_emu #(
    .W        (W),
    .NCH      (NCH),
    .MAXSTEP  (MAXSTEP),
    .RAMP_DIV (RAMP_DIV),
    .RAMP_STEP(RAMP_STEP),
    .DEADZONE (DEADZONE)
  ) dut (
    .clk_sys     (clk),
    .reset_n     (rst_n),
    .ps2_mouse   (ps2_mouse),
    .mouse_ch    (mouse_ch),
    .mode        (mode),
    .ana_x       (ana_x),
    .ana_y       (ana_y),
    .dig         (dig),
    .ana_fire    (ana_fire),
    .recenter    (recenter),
    .axis_x      (axis_x),
    .axis_y      (axis_y),
    .fire        (fire),
    .mouse_active(mouse_active)
  );

  task automatic chk(input string name, input integer got, input integer exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int lim(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int sx9(input logic s, input logic [7:0] b);
    return s ? int'(b) - 256 : int'(b);
  endfunction

  function automatic int ramp(input int v, input bit pos, input bit neg);
    int dir;
    dir = int'(pos) - int'(neg);
    if (dir != 0) return lim(v + dir * RAMP_STEP, LO, HI);
    if (v > 0) return lim(v - RAMP_STEP, 0, HI);
    return lim(v + RAMP_STEP, LO, 0);
  endfunction

  // Model state: what the outputs must be after each rising edge.
  int m_acc_x[NCH];
  int m_acc_y[NCH];
  int m_out_x[NCH];
  int m_out_y[NCH];
  bit m_act[NCH];
  bit m_fire[NCH];
  bit m_first    = 1'b1;
  bit m_prev_stb = 1'b0;
  int m_cyc      = 0;
  bit mp_pkt, mp_tick, mp_mine, mp_idle, mp_was, mp_owned;
  int mp_dx, mp_dy, mp_md, mp_ax, mp_ay;
  logic [4:0] mp_dg;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        m_acc_x[c] = 0; m_acc_y[c] = 0; m_out_x[c] = 0; m_out_y[c] = 0;
        m_act[c]   = 1'b0; m_fire[c] = 1'b0;
      end
      m_first    = 1'b1;
      m_prev_stb = 1'b0;
      m_cyc      = 0;
    end else begin
      mp_pkt     = !m_first && (ps2_mouse[24] != m_prev_stb) && !recenter;
      m_first    = 1'b0;
      m_prev_stb = ps2_mouse[24];
      mp_tick    = (m_cyc % RAMP_DIV) == RAMP_DIV - 1;
      m_cyc++;
      mp_dx = lim(sx9(ps2_mouse[4], ps2_mouse[15:8]), -MAXSTEP, MAXSTEP);
      mp_dy = lim(sx9(ps2_mouse[5], ps2_mouse[23:16]), -MAXSTEP, MAXSTEP);
      for (int c = 0; c < NCH; c++) begin
        mp_md   = int'(mode[2*c +: 2]);
        mp_ax   = int'($signed(ana_x[c*W +: W]));
        mp_ay   = int'($signed(ana_y[c*W +: W]));
        mp_dg   = dig[5*c +: 5];
        mp_mine = mp_pkt && (int'(mouse_ch) == c);
        mp_idle = iabs(mp_ax) <= DEADZONE && iabs(mp_ay) <= DEADZONE && mp_dg == 5'd0;
        mp_was  = m_act[c];
        if (recenter) m_act[c] = 1'b0;
        else if (mp_md == 3) begin
          if (!mp_idle) m_act[c] = 1'b0;
          else if (mp_mine) m_act[c] = 1'b1;
        end
        mp_owned = (mp_md == 1) || (mp_md == 3 && m_act[c]);
        if (recenter || (mp_was && !m_act[c])) begin
          m_acc_x[c] = 0;
          m_acc_y[c] = 0;
        end else if (mp_mine && mp_owned) begin
          m_acc_x[c] = lim(m_acc_x[c] + mp_dx, LO, HI);
          m_acc_y[c] = lim(m_acc_y[c] - mp_dy, LO, HI);
        end else if (mp_md == 2 && mp_tick) begin
          m_acc_x[c] = ramp(m_acc_x[c], mp_dg[0], mp_dg[1]);
          m_acc_y[c] = ramp(m_acc_y[c], mp_dg[3], mp_dg[2]);
        end
        if (mp_owned) begin
          m_out_x[c] = m_acc_x[c]; m_out_y[c] = m_acc_y[c];
          m_fire[c]  = ps2_mouse[1:0] != 2'b00;
        end else if (mp_md == 2) begin
          m_out_x[c] = m_acc_x[c]; m_out_y[c] = m_acc_y[c];
          m_fire[c]  = mp_dg[4];
        end else begin
          m_out_x[c] = mp_ax; m_out_y[c] = mp_ay;
          m_fire[c]  = ana_fire[c] | (mp_md == 3 && mp_dg[4]);
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("axis_x[%0d]", c), $signed(axis_x[c*W +: W]), m_out_x[c]);
      chk($sformatf("axis_y[%0d]", c), $signed(axis_y[c*W +: W]), m_out_y[c]);
      chk($sformatf("fire[%0d]", c), fire[c], int'(m_fire[c]));
      chk($sformatf("mouse_active[%0d]", c), mouse_active[c], int'(m_act[c]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int dx, input int dy);
    logic [8:0] vx, vy;
    vx = 9'(dx);
    vy = 9'(dy);
    ps2_mouse[15:8]  = vx[7:0];
    ps2_mouse[4]     = vx[8];
    ps2_mouse[23:16] = vy[7:0];
    ps2_mouse[5]     = vy[8];
    ps2_mouse[24]    = ~ps2_mouse[24];
  endtask

  function automatic integer x0();
    return $signed(axis_x[W-1:0]);
  endfunction

  function automatic integer y0();
    return $signed(axis_y[W-1:0]);
  endfunction

  task automatic wait_change(input string name, input int exp);
    integer prev;
    bit     seen;
    prev = x0();
    seen = 1'b0;
    for (int i = 0; i < 3 * RAMP_DIV && !seen; i++) begin
      step();
      if (x0() !== prev) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: no change in %0d cycles, got %0d, required %0d",
               name, 3 * RAMP_DIV, prev, exp);
    end else begin
      chk(name, x0(), exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ps2_mouse[24] = 1'b1;
    mode          = {2'd0, 2'd1};
    repeat (3) step();
    chk("rst_axis_x", axis_x, 0);
    chk("rst_axis_y", axis_y, 0);
    chk("rst_fire", fire, 0);
    chk("rst_mouse_active", mouse_active, 0);

    // Strobe differs from the reset copy, yet no packet may be taken on release.
    rst_n = 1'b1;
    step();
    chk("no_pkt_after_release", x0(), 0);

    send(200, 0);
    step();
    chk("mouse_dx200_clamped", x0(), 10);
    for (int i = 0; i < 13; i++) begin
      send(200, 0);
      step();
    end
    chk("mouse_x_saturates", x0(), 127);

    recenter = 1'b1;
    step();
    recenter = 1'b0;
    chk("recenter_x", x0(), 0);
    send(0, 5);
    step();
    chk("mouse_dy5_inverted", y0(), -5);

    mode = {2'd0, 2'd3};
    step();
    send(9, 0);
    recenter = 1'b1;
    step();
    recenter = 1'b0;
    chk("recenter_beats_pkt_active", mouse_active[0], 0);
    mode = {2'd0, 2'd1};
    step();
    chk("recenter_beats_pkt_acc_x", x0(), 0);
    chk("recenter_beats_pkt_acc_y", y0(), 0);

    mode = {2'd0, 2'd3};
    step();
    send(7, 0);
    step();
    chk("auto_pkt_active", mouse_active[0], 1);
    chk("auto_pkt_x", x0(), 7);
    ana_x[W-1:0] = 8'sd20;
    step();
    chk("auto_stick_active", mouse_active[0], 0);
    chk("auto_stick_x", x0(), 20);
    ana_x = '0;
    send(3, 0);
    step();
    chk("auto_acc_was_zeroed", x0(), 3);

    mode     = {2'd0, 2'd2};
    recenter = 1'b1;
    step();
    recenter = 1'b0;
    dig[0]   = 1'b1;
    wait_change("ramp_right_1", 4);
    wait_change("ramp_right_2", 8);
    wait_change("ramp_right_3", 12);
    dig[0] = 1'b0;
    wait_change("ramp_back_8", 8);
    wait_change("ramp_back_4", 4);
    wait_change("ramp_back_0", 0);
    repeat (3 * RAMP_DIV) step();
    chk("ramp_stays_0", x0(), 0);

    dig[0] = 1'b1;
    for (int k = 1; k <= 10; k++) wait_change($sformatf("ramp_up_%0d", k), 4 * k);
    rst_n = 1'b0;
    #1;
    chk("midramp_rst_axis_x", axis_x, 0);
    chk("midramp_rst_axis_y", axis_y, 0);
    chk("midramp_rst_fire", fire, 0);
    chk("midramp_rst_active", mouse_active, 0);
    dig              = '0;
    mode             = {2'd0, 2'd1};
    ps2_mouse[15:8]  = 8'd5;
    ps2_mouse[4]     = 1'b0;
    ps2_mouse[24]    = 1'b1;
    step();
    rst_n = 1'b1;
    repeat (4) step();
    chk("no_spurious_pkt_x", x0(), 0);
    chk("no_spurious_pkt_y", y0(), 0);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) mode = 4'($urandom);
      if ($urandom_range(0, 29) == 0) mouse_ch = 1'($urandom);
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 19) == 0) ana_x[c*W +: W] = W'($urandom);
        else ana_x[c*W +: W] = W'(int'($urandom_range(0, 32)) - 16);
        if ($urandom_range(0, 19) == 0) ana_y[c*W +: W] = W'($urandom);
        else ana_y[c*W +: W] = W'(int'($urandom_range(0, 32)) - 16);
      end
      dig            = ($urandom_range(0, 7) == 0) ? 10'($urandom) : '0;
      ana_fire       = 2'($urandom);
      ps2_mouse[1:0] = 2'($urandom);
      if ($urandom_range(0, 2) == 0)
        send(int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256);
      recenter = ($urandom_range(0, 49) == 0);
      step();
    end
    recenter = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/analog_axis_emu.md
ANALOG_AXIS_EMU -- requirements
Module: analog_axis_emu

Interface
REQ-001 Parameter W, default 8: axis width; outputs signed two's complement, range -2^(W-1)..2^(W-1)-1.
REQ-002 Parameter NCH, default 2: number of joystick channels.
REQ-003 Parameter MAXSTEP, default 10: per-packet mouse delta clamp magnitude.
REQ-004 Parameter RAMP_DIV, default 65536: clk_sys cycles per digital-ramp tick.
REQ-005 Parameter RAMP_STEP, default 4: axis change per ramp tick.
REQ-006 Parameter DEADZONE, default 16: analog deviation counted as stick activity in auto mode.
REQ-007 clk_sys  in  1  system clock; the block has one clock and all state is clocked on its rising edge.
REQ-008 reset_n  in  1  asynchronous active-low reset.
REQ-009 ps2_mouse  in  25  MiSTer mouse word: [24] toggle strobe, [4]/[5] X/Y sign, [15:8] X, [23:16] Y, [1:0] buttons.
REQ-010 mouse_ch  in  $clog2(NCH)  channel that receives mouse motion.
REQ-011 mode  in  2*NCH  per channel: 0 analog, 1 mouse, 2 digital ramp, 3 auto.
REQ-012 ana_x, ana_y  in  W*NCH each  signed analog stick inputs.
REQ-013 dig  in  5*NCH  per channel {fire, up, down, left, right}.
REQ-014 ana_fire  in  NCH  analog stick fire.
REQ-015 recenter  in  1  synchronous pulse: zero all accumulators, clear mouse_active.
REQ-016 axis_x, axis_y  out  W*NCH each  registered axis outputs.
REQ-017 fire  out  NCH  registered fire outputs.
REQ-018 mouse_active  out  NCH  auto-mode mouse ownership flags.

Function
REQ-019 Mouse packet is accepted on the first cycle in which ps2_mouse[24] differs from its registered copy; the strobe copy is updated every cycle.
REQ-020 dx = 9-bit sign-extended {ps2_mouse[4], ps2_mouse[15:8]}; dy likewise from [5] and [23:16].
REQ-021 Each delta is clamped to [-MAXSTEP, +MAXSTEP] before accumulation.
REQ-022 Mouse X accumulator += clamped dx; Y accumulator -= clamped dy (screen-down is negative); W+2-bit intermediate sum, saturated to the W-bit range, never wrapped.
REQ-023 Mouse accumulation applies only to channel mouse_ch when its mode is 1 or 3; other channels ignore the packet.
REQ-024 Ramp prescaler is a free-running counter producing a one-cycle tick every RAMP_DIV cycles.
REQ-025 Mode 2 on a tick: a held direction moves the axis by RAMP_STEP toward the corresponding limit with saturation; with no direction held, or with both opposing directions held, the axis moves RAMP_STEP toward 0 and stops exactly at 0 with no overshoot.
REQ-026 Mode 0: axis outputs equal ana_x/ana_y registered, giving 1-cycle latency; fire = ana_fire.
REQ-027 Mode 1: outputs equal the mouse accumulator; fire = |ps2_mouse[1:0].
REQ-028 Mode 3: mouse_active is set by an accepted packet on that channel; it clears when |ana| > DEADZONE on either axis, when any dig bit is set, or on recenter. When the flag is set, the channel behaves as mode 1; when clear, as mode 0 with fire = ana_fire | dig fire.
REQ-029 A mouse_active 1->0 transition zeroes that channel's mouse accumulators in the same cycle.
REQ-030 Output update latency is 1 clk_sys cycle after the accepting strobe, tick or input change.
REQ-031 When recenter and a packet arrive in the same cycle, recenter wins and the packet is discarded.
REQ-032 A mode change takes effect on the next cycle; accumulators are retained except as stated in REQ-029.
REQ-033 A mouse_ch value >= NCH causes packets to be discarded.

Reset
REQ-034 While reset_n is low: all accumulators, axis_x, axis_y, fire, mouse_active, the prescaler and the strobe copy are 0.
REQ-035 An accepted packet is never detected on the first cycle after reset release; the strobe copy loads ps2_mouse[24] on that cycle.

Structure
REQ-036 The package analog_axis_pkg holds the mode enum (MODE_ANALOG, MODE_MOUSE, MODE_RAMP, MODE_AUTO) and the saturate and clamp functions.
REQ-037 The sub-module axis_accum implements one saturating accumulator with clear, add-delta, and ramp-toward-target/zero operations; it is instantiated 2*NCH times.

Verification
REQ-038 Mode 1, W=8: packet dx=+200 -> axis_x=+10; 13 further such packets -> axis_x saturates at +127.
REQ-039 Mode 1: packet dy=+5 -> axis_y=-5 one cycle after the strobe toggle.
REQ-040 Mode 2, RAMP_STEP=4: hold right for 3 ticks -> axis_x=12; release -> 8, 4, 0, then stays at 0.
REQ-041 Mode 3: packet dx=+7 -> mouse_active=1, axis_x=7; then ana_x=+20 -> mouse_active=0, axis_x=20, accumulator=0.
REQ-042 Recenter asserted in the same cycle as a packet -> accumulators stay 0 and mouse_active=0.
REQ-043 Assert reset_n low mid-ramp at axis=+40 -> all outputs 0 immediately; after release, no spurious packet is accepted.
